// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-specifier width default and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam int unsigned REG_W_DEFAULT = 5;
  localparam int unsigned ZERO_REG      = 0;

endpackage

// File: rtl/and_module.sv
// Two-input AND used for the branch-taken decision.
module and_module (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: branch flush, load-use bubble and
// front-end stall while the multi-cycle multiply/divide unit is busy.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = REG_W_DEFAULT,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic             pc_src,
  output logic             md_busy,
  output logic             md_done
);

  // The md_start cycle and the final (cnt==0) cycle both count as busy,
  // hence the load value is latency minus two.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam int unsigned      MAX_CYC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam logic [CNT_W:0]   MAX_LOAD = (CNT_W + 1)'(MAX_CYC - 2);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               taken;
  logic               lu;

  and_module u_taken (
    .a (ex_branch),
    .b (ex_zero),
    .y (taken)
  );

  assign lu = ex_mem_read && (ex_rt != REG_W'(ZERO_REG)) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    pc_src      = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;

    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          // A taken branch wins over md_start: the start is on the wrong path.
          if (taken) begin
            pc_src      = 1'b1;
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (md_start) begin
            state_next = ST_MD_WAIT;
            cnt_next   = md_is_div ? DIV_LOAD : MUL_LOAD;
            md_busy    = 1'b1;
            ex_hold    = 1'b1;
          end else if (lu) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          md_busy = 1'b1;
          ex_hold = 1'b1;
          if (cnt == '0) begin
            md_done    = 1'b1;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  a_cnt_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_MD_WAIT) |-> ({1'b0, cnt} <= MAX_LOAD));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a scoreboard queue of
// expected output vectors.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch, ex_zero, md_start, md_is_div;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       ex_hold, pc_src, md_busy, md_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, pc_src, md_busy, md_done}
  localparam logic [7:0] E_RST   = 8'b0011_0000;
  localparam logic [7:0] E_IDLE  = 8'b1100_0000;
  localparam logic [7:0] E_LU    = 8'b0001_0000;
  localparam logic [7:0] E_TAKEN = 8'b1011_0100;
  localparam logic [7:0] E_BUSY  = 8'b0000_1010;
  localparam logic [7:0] E_DONE  = 8'b0000_1011;

  hazard_ctrl #(
    .REG_W      (5),
    .MUL_CYCLES (4),
    .DIV_CYCLES (8),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .ex_branch   (ex_branch),
    .ex_zero     (ex_zero),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_hold     (ex_hold),
    .pc_src      (pc_src),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag);
    logic [7:0] exp;
    logic [7:0] obs;
    exp = sb.pop_front();
    obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, pc_src, md_busy, md_done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: expectation queued when stimulus is applied, checked mid-cycle.
  task automatic cyc(input logic [7:0] exp, input string tag);
    sb.push_back(exp);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic now(input logic [7:0] exp, input string tag);
    sb.push_back(exp);
    #1;
    compare(tag);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  task automatic randomize_inputs();
    id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
    id_uses_rt = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_branch = 1'($urandom); ex_zero = 1'($urandom);
    md_start = 1'($urandom); md_is_div = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      cyc(E_RST, "reset");
    end
    idle();
    rst_n = 1'b1;
    cyc(E_IDLE, "release_idle");

    // Load-use
    set_lu();
    cyc(E_LU, "lu_rs");
    idle();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    cyc(E_LU, "lu_rt");
    id_uses_rt = 1'b0;
    cyc(E_IDLE, "lu_rt_unused");
    idle();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cyc(E_IDLE, "lu_reg0");
    idle();
    cyc(E_IDLE, "after_lu");

    // Branch over load-use
    set_lu(); ex_branch = 1'b1; ex_zero = 1'b1;
    cyc(E_TAKEN, "taken_over_lu");
    ex_zero = 1'b0;
    cyc(E_LU, "not_taken_lu");
    idle(); ex_branch = 1'b1; ex_zero = 1'b1;
    cyc(E_TAKEN, "taken_plain");

    // Multiply: 4 busy cycles
    idle(); md_start = 1'b1; md_is_div = 1'b0;
    cyc(E_BUSY, "mul_c1");
    idle();
    cyc(E_BUSY, "mul_c2");
    cyc(E_BUSY, "mul_c3");
    cyc(E_DONE, "mul_c4");
    cyc(E_IDLE, "mul_c5");

    // Divide with noise while busy
    idle(); md_start = 1'b1; md_is_div = 1'b1;
    cyc(E_BUSY, "div_c1");
    for (int c = 2; c <= 7; c++) begin
      idle();
      if (c % 2 == 0) md_start = 1'b1;
      else begin ex_branch = 1'b1; ex_zero = 1'b1; end
      if (c == 5) set_lu();
      cyc(E_BUSY, $sformatf("div_c%0d", c));
    end
    idle(); ex_branch = 1'b1; ex_zero = 1'b1; md_start = 1'b1;
    cyc(E_DONE, "div_c8");
    idle(); set_lu();
    cyc(E_LU, "div_release_lu");
    idle();
    cyc(E_IDLE, "div_after");

    // Abort in busy cycle 3 of a divide
    md_start = 1'b1; md_is_div = 1'b1;
    cyc(E_BUSY, "abort_c1");
    idle();
    cyc(E_BUSY, "abort_c2");
    now(E_BUSY, "abort_c3_pre");
    rst_n = 1'b0;
    now(E_RST, "abort_immediate");
    cyc(E_RST, "abort_held");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(E_IDLE, "abort_run");

    // Fresh multiply after abort
    md_start = 1'b1; md_is_div = 1'b0;
    cyc(E_BUSY, "post_abort_mul_c1");
    idle();
    cyc(E_BUSY, "post_abort_mul_c2");
    cyc(E_BUSY, "post_abort_mul_c3");
    cyc(E_DONE, "post_abort_mul_c4");
    cyc(E_IDLE, "post_abort_mul_c5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
